// File: rtl/seg_mux_driver.sv
// seg_mux_driver: time-multiplexes two hex digits onto one shared common-anode
// 7-segment bus. Sequence: BLANK2 -> SHOW1 -> BLANK1 -> SHOW2 -> BLANK2 ...
// The blank phases turn both anodes off between digits to prevent ghosting.
// All outputs are registered and change on the same edge as the state register.
// Optional feature macro: SEG_MUX_DIM_EN adds a 2-bit dim input that shortens
// the active-anode on-time inside each SHOW phase.
module seg_mux_driver #(
  parameter int REFRESH_CNT = 20000,
  parameter int BLANK_CNT   = 64,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
`ifdef SEG_MUX_DIM_EN
  input  logic [1:0] dim,
`endif
  output logic [6:0] seg,
  output logic       anode1,
  output logic       anode2,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    BLANK2 = 2'd0,
    SHOW1  = 2'd1,
    BLANK1 = 2'd2,
    SHOW2  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_CNT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CNT - 1);

  // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_digit1;
  logic [3:0]       r_digit2;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_last;
  logic             w_enter1;
  logic             w_enter2;
  logic [3:0]       w_digit1_next;
  logic [3:0]       w_digit2_next;
  logic             w_on;
  logic [6:0]       w_seg_next;
  logic             w_anode1_next;
  logic             w_anode2_next;
  logic             w_tick_next;

`ifdef SEG_MUX_DIM_EN
  logic [1:0]       r_dim;
  logic [1:0]       w_dim_next;
  logic [33:0]      w_thr;

  // Dim level is captured on SHOW entry; the anode stays on only while the
  // phase counter is below a quarter-step fraction of the SHOW length.
  always_comb begin
    w_dim_next = (w_enter1 || w_enter2) ? dim : r_dim;
    w_thr      = (34'(REFRESH_CNT) * (34'(w_dim_next) + 34'd1)) >> 2;
    w_on       = (34'(w_cnt_next) < w_thr);
  end
`else
  // Without dimming the active anode is on for the whole SHOW phase.
  always_comb begin
    w_on = 1'b1;
  end
`endif

  // Next state, next counter and next outputs, so the registered outputs line
  // up with the state register without an extra cycle of latency.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    if (r_state == SHOW1 || r_state == SHOW2) begin
      w_last = (r_cnt == SHOW_LAST);
    end else begin
      w_last = (r_cnt == BLANK_LAST);
    end
    if (w_last) begin
      w_cnt_next = '0;
      case (r_state)
        BLANK2:  w_state_next = SHOW1;
        SHOW1:   w_state_next = BLANK1;
        BLANK1:  w_state_next = SHOW2;
        default: w_state_next = BLANK2;
      endcase
    end
    w_enter1      = w_last && (r_state == BLANK2);
    w_enter2      = w_last && (r_state == BLANK1);
    w_digit1_next = w_enter1 ? digit1 : r_digit1;
    w_digit2_next = w_enter2 ? digit2 : r_digit2;

    w_seg_next    = 7'h7F;
    w_anode1_next = 1'b1;
    w_anode2_next = 1'b1;
    w_tick_next   = 1'b0;
    case (w_state_next)
      SHOW1: begin
        w_seg_next    = hex7(w_digit1_next);
        w_anode1_next = ~w_on;
        w_tick_next   = (w_cnt_next == '0);
      end
      SHOW2: begin
        w_seg_next    = hex7(w_digit2_next);
        w_anode2_next = ~w_on;
      end
      default: ;
    endcase
  end

  // FSM state, phase counter, digit latches and registered pin drivers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= BLANK2;
      r_cnt      <= '0;
      r_digit1   <= '0;
      r_digit2   <= '0;
      seg        <= 7'h7F;
      anode1     <= 1'b1;
      anode2     <= 1'b1;
      frame_tick <= 1'b0;
`ifdef SEG_MUX_DIM_EN
      r_dim      <= '0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_digit1   <= w_digit1_next;
      r_digit2   <= w_digit2_next;
      seg        <= w_seg_next;
      anode1     <= w_anode1_next;
      anode2     <= w_anode2_next;
      frame_tick <= w_tick_next;
`ifdef SEG_MUX_DIM_EN
      r_dim      <= w_dim_next;
`endif
    end
  end

endmodule
